trng_key_fifo: RTL and testbench

//  Downstream consumer of the TRNG core's key handshake (key_ready/out_key/ack_read).

---
 rtl/trng_key_fifo.sv | 92 +++++++++
 tb/tb_trng_key_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/trng_key_fifo.sv
// Buffers TRNG key words behind a capture/ack FSM and drains them through a
// show-ahead valid/ready port, with a registered level threshold interrupt.
module trng_key_fifo #(
    parameter int N_BITS_KEY = 32,
    parameter int DEPTH      = 8,
    parameter int THRESH     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         flush_i,
    input  logic                         key_ready_i,
    input  logic [N_BITS_KEY-1:0]        key_i,
    output logic                         ack_read_o,
    output logic [N_BITS_KEY-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         thresh_intr_o
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(THRESH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK      = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;

    logic [1:0]            state, state_next;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         count_next;
    logic                  push, pop;
    logic [N_BITS_KEY-1:0] mem [DEPTH];

    // Full blocks capture so the TRNG is held off rather than losing a word.
    assign push = (state == IDLE) && enable_i && key_ready_i && !full_o && !flush_i;
    assign pop  = !empty_o && ready_i && !flush_i;

    assign ack_read_o = (state == ACK);
    assign valid_o    = !empty_o;
    assign data_o     = empty_o ? '0 : mem[rd_ptr];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (push) state_next = ACK;
            ACK:      state_next = WAIT_LOW;
            WAIT_LOW: if (!key_ready_i) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    always_comb begin
        count_next = level_o + LW'(push) - LW'(pop);
        if (flush_i) count_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_o       <= '0;
            full_o        <= 1'b0;
            empty_o       <= 1'b1;
            thresh_intr_o <= 1'b0;
        end else begin
            state         <= state_next;
            level_o       <= count_next;
            full_o        <= (count_next == DEPTH_L);
            empty_o       <= (count_next == '0);
            thresh_intr_o <= (count_next >= THRESH_L);
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is deliberately left unreset; data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_i;
    end
endmodule

// File: tb/tb_trng_key_fifo.sv
// Directed bench for trng_key_fifo with a queue scoreboard of expected key words.
module tb_trng_key_fifo;
    logic        clk, rst_n, enable_i, flush_i, key_ready_i, ready_i;
    logic [31:0] key_i, data_o;
    logic        ack_read_o, valid_o, full_o, empty_o, thresh_intr_o;
    logic [3:0]  level_o;

    int passed = 0;
    int total  = 0;
    int acks;
    int maxlvl;
    logic [31:0] sb[$];
    logic [31:0] exp_w;

    trng_key_fifo #(.N_BITS_KEY(32), .DEPTH(8), .THRESH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .flush_i(flush_i),
        .key_ready_i(key_ready_i), .key_i(key_i), .ack_read_o(ack_read_o),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .level_o(level_o),
        .full_o(full_o), .empty_o(empty_o), .thresh_intr_o(thresh_intr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, ack_read_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_empty"}, empty_o, 1);
        chk({tag, "_full"}, full_o, 0);
        chk({tag, "_thr"}, thresh_intr_o, 0);
        chk({tag, "_lvl"}, level_o, 0);
        chk({tag, "_data"}, data_o, 0);
    endtask

    // Capture one key from IDLE with no concurrent pop; FSM back in IDLE afterwards.
    task automatic send_key(input logic [31:0] k, input int exp_lvl);
        key_i = k; key_ready_i = 1'b1;
        sb.push_back(k);
        tick();
        chk("send_ack", ack_read_o, 1);
        chk("send_lvl", level_o, 64'(exp_lvl));
        chk("send_thr", thresh_intr_o, 64'(exp_lvl >= 4));
        key_ready_i = 1'b0;
        tick();
        chk("send_ack_low", ack_read_o, 0);
        tick();
    endtask

    task automatic pop_check(input string tag);
        exp_w = sb.pop_front();
        ready_i = 1'b1;
        chk({tag, "_valid"}, valid_o, 1);
        chk({tag, "_data"}, data_o, 64'(exp_w));
        tick();
        ready_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable_i = 1'b0; flush_i = 1'b0; key_ready_i = 1'b0;
        ready_i = 1'b0; key_i = '0;
        tick(); tick();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // 1: key held high three cycles yields exactly one ack
        enable_i = 1'b1; key_ready_i = 1'b1; key_i = 32'hDEADBEEF;
        sb.push_back(32'hDEADBEEF);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_read_o) acks++;
        end
        key_ready_i = 1'b0;
        tick();
        if (ack_read_o) acks++;
        tick();
        chk("t1_acks", acks, 1);
        chk("t1_lvl", level_o, 1);
        pop_check("t1_pop");
        chk("t1_empty", empty_o, 1);

        // 2: fill to full, back-pressure, pop frees one slot
        for (int i = 1; i <= 8; i++) send_key(32'(i), i);
        chk("t2_full", full_o, 1);
        key_ready_i = 1'b1; key_i = 32'h9;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_read_o) acks++;
        end
        chk("t2_no_ack9", acks, 0);
        chk("t2_lvl8", level_o, 8);
        pop_check("t2_pop1");
        chk("t2_lvl7", level_o, 7);
        chk("t2_notfull", full_o, 0);
        chk("t2_ack_wait", ack_read_o, 0);
        sb.push_back(32'h9);
        tick();
        chk("t2_ack9", ack_read_o, 1);
        chk("t2_lvl8b", level_o, 8);
        key_ready_i = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) pop_check("t2_drain");
        chk("t2_empty", empty_o, 1);
        chk("t2_thr_low", thresh_intr_o, 0);

        // 3: continuous producer with consumer always ready
        ready_i = 1'b1;
        maxlvl = 0;
        for (int i = 0; i < 20; i++) begin
            key_i = 32'h100 + 32'(i); key_ready_i = 1'b1;
            sb.push_back(key_i);
            tick();
            if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
            exp_w = sb.pop_front();
            chk("t3_data", data_o, 64'(exp_w));
            key_ready_i = 1'b0;
            tick();
            if (int'(level_o) > maxlvl) maxlvl = int'(level_o);
            tick();
        end
        chk("t3_maxlvl", maxlvl, 1);
        chk("t3_empty", empty_o, 1);
        ready_i = 1'b0;

        // 4: flush during ACK with level 3; FSM returns to IDLE
        send_key(32'hA1, 1);
        send_key(32'hA2, 2);
        key_i = 32'hA3; key_ready_i = 1'b1;
        tick();
        chk("t4_ack", ack_read_o, 1);
        chk("t4_lvl3", level_o, 3);
        flush_i = 1'b1; key_i = 32'hF00D;
        tick();
        flush_i = 1'b0;
        sb.delete();
        chk("t4_ack_cancel", ack_read_o, 0);
        chk("t4_lvl0", level_o, 0);
        chk("t4_empty", empty_o, 1);
        chk("t4_thr", thresh_intr_o, 0);
        sb.push_back(32'hF00D);
        tick();
        chk("t4_recapture", ack_read_o, 1);
        key_ready_i = 1'b0;
        tick(); tick();

        // 5: async reset while in WAIT_LOW at level 5
        for (int i = 2; i <= 4; i++) send_key(32'hB0 + 32'(i), i);
        key_i = 32'hB5; key_ready_i = 1'b1;
        tick(); tick();
        chk("t5_lvl5", level_o, 5);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        key_ready_i = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_read_o) acks++;
        end
        chk("t5_no_ack", acks, 0);
        chk("t5_lvl", level_o, 0);
        send_key(32'hC0FFEE, 1);
        pop_check("t5_pop");

        // 6: disabled capture ignores key_ready
        enable_i = 1'b0; key_ready_i = 1'b1; key_i = 32'h5555;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_read_o) acks++;
        end
        chk("t6_no_ack", acks, 0);
        chk("t6_lvl", level_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
